// File: rtl/writeback_stage_if.sv
// Signal bundle between the MEM stage / data memory (master) and the write-back stage (slave).
interface writeback_stage_if;
  logic        stall;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_alu;
  logic [4:0]  m_rd;
  logic        m_rf_wen;
  logic        m_csr_wen;
  logic [1:0]  m_wb_sel;
  logic [2:0]  m_funct3;
  logic [1:0]  m_addr_lo;
  logic [31:0] dmem_rdata;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        csr_load;
  logic [31:0] cycle;
  logic [31:0] instret;

  modport master (
    output stall, m_valid, m_pc, m_alu, m_rd, m_rf_wen, m_csr_wen,
           m_wb_sel, m_funct3, m_addr_lo, dmem_rdata,
    input  wen, waddr, wdata, csr_load, cycle, instret
  );

  modport slave (
    input  stall, m_valid, m_pc, m_alu, m_rd, m_rf_wen, m_csr_wen,
           m_wb_sel, m_funct3, m_addr_lo, dmem_rdata,
    output wen, waddr, wdata, csr_load, cycle, instret
  );
endinterface

// File: rtl/writeback_stage.sv
// RV32 write-back stage: MEM/WB register, load alignment/extension, register-file
// and CSR write port, plus the cycle and instret counters.
module writeback_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              reset,
  writeback_stage_if.slave bus
);
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [31:0] wb_alu;
  logic [4:0]  wb_rd;
  logic        wb_rf_wen;
  logic        wb_csr_wen;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_funct3;
  logic [1:0]  wb_addr_lo;

  logic        held_valid;
  logic [31:0] held_data;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;

  logic        commit;
  logic [31:0] src;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] wdata_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid   <= 1'b0;
      wb_pc      <= RESET_PC;
      wb_alu     <= '0;
      wb_rd      <= '0;
      wb_rf_wen  <= 1'b0;
      wb_csr_wen <= 1'b0;
      wb_sel     <= '0;
      wb_funct3  <= '0;
      wb_addr_lo <= '0;
    end else if (!bus.stall) begin
      wb_valid   <= bus.m_valid;
      wb_pc      <= bus.m_pc;
      wb_alu     <= bus.m_alu;
      wb_rd      <= bus.m_rd;
      wb_rf_wen  <= bus.m_rf_wen;
      wb_csr_wen <= bus.m_csr_wen;
      wb_sel     <= bus.m_wb_sel;
      wb_funct3  <= bus.m_funct3;
      wb_addr_lo <= bus.m_addr_lo;
    end
  end

  // The memory only presents the load word in the first WB cycle, so keep it for the rest of a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_valid <= 1'b0;
      held_data  <= '0;
    end else if (!bus.stall) begin
      held_valid <= 1'b0;
    end else if (!held_valid) begin
      held_valid <= 1'b1;
      held_data  <= bus.dmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (commit) begin
        instret_count <= instret_count + 32'd1;
      end
    end
  end

  assign commit    = wb_valid & ~bus.stall;
  assign src       = held_valid ? held_data : bus.dmem_rdata;
  assign load_byte = 8'(src >> {wb_addr_lo, 3'b000});
  assign load_half = 16'(src >> {wb_addr_lo[1], 4'b0000});

  always_comb begin
    load_data = src;
    case (wb_funct3)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'd0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = src;
    endcase
  end

  always_comb begin
    wdata_sel = '0;
    case (wb_sel)
      2'd0:    wdata_sel = wb_alu;
      2'd1:    wdata_sel = load_data;
      2'd2:    wdata_sel = wb_pc + 32'd4;
      default: wdata_sel = '0;
    endcase
  end

  assign bus.wen      = commit & wb_rf_wen & (wb_rd != 5'd0);
  assign bus.csr_load = commit & wb_csr_wen;
  assign bus.waddr    = wb_rd;
  assign bus.wdata    = wdata_sel;
  assign bus.cycle    = cycle_count;
  assign bus.instret  = instret_count;
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_writeback_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rf_wen;
    logic        csr_wen;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  off;
  } ins_t;

  localparam ins_t BUBBLE = '0;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  writeback_stage_if bus ();

  writeback_stage #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: the instruction sitting in WB, how long it has been stalled, and the word seen when the stall began.
  logic        m_ready = 1'b0;
  ins_t        m_ins;
  int          m_run;
  logic [31:0] m_word;
  logic [31:0] m_cycle;
  logic [31:0] m_instret;

  function automatic ins_t current_ins();
    ins_t i;
    i.valid   = bus.m_valid;
    i.pc      = bus.m_pc;
    i.alu     = bus.m_alu;
    i.rd      = bus.m_rd;
    i.rf_wen  = bus.m_rf_wen;
    i.csr_wen = bus.m_csr_wen;
    i.sel     = bus.m_wb_sel;
    i.f3      = bus.m_funct3;
    i.off     = bus.m_addr_lo;
    return i;
  endfunction

  function automatic ins_t reset_ins();
    ins_t i;
    i    = '0;
    i.pc = RESET_PC;
    return i;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? b - 256 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h - 65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic exp_commit();
    return m_ins.valid && !bus.stall;
  endfunction

  function automatic logic [31:0] exp_wdata();
    case (m_ins.sel)
      2'd0:    return m_ins.alu;
      2'd1:    return load_val(m_ins.f3, m_ins.off, (m_run > 0) ? m_word : bus.dmem_rdata);
      2'd2:    return m_ins.pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ready   <= 1'b1;
      m_ins     <= reset_ins();
      m_run     <= 0;
      m_cycle   <= 32'd0;
      m_instret <= 32'd0;
    end else begin
      m_cycle <= m_cycle + 32'd1;
      if (m_ins.valid && !bus.stall) m_instret <= m_instret + 32'd1;
      if (!bus.stall) begin
        m_ins <= current_ins();
        m_run <= 0;
      end else begin
        if (m_run == 0) m_word <= bus.dmem_rdata;
        m_run <= m_run + 1;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ready) begin
      check_output("model.wen", 32'(bus.wen), 32'(exp_commit() && m_ins.rf_wen && m_ins.rd != 5'd0));
      check_output("model.csr_load", 32'(bus.csr_load), 32'(exp_commit() && m_ins.csr_wen));
      check_output("model.waddr", 32'(bus.waddr), 32'(m_ins.rd));
      check_output("model.wdata", bus.wdata, exp_wdata());
      check_output("model.cycle", bus.cycle, m_cycle);
      check_output("model.instret", bus.instret, m_instret);
    end
  end

  task automatic apply_stimulus(input logic rst, input logic st, input ins_t i, input logic [31:0] d);
    reset          = rst;
    bus.stall      = st;
    bus.m_valid    = i.valid;
    bus.m_pc       = i.pc;
    bus.m_alu      = i.alu;
    bus.m_rd       = i.rd;
    bus.m_rf_wen   = i.rf_wen;
    bus.m_csr_wen  = i.csr_wen;
    bus.m_wb_sel   = i.sel;
    bus.m_funct3   = i.f3;
    bus.m_addr_lo  = i.off;
    bus.dmem_rdata = d;
  endtask

  function automatic ins_t make_ins(input logic valid, input logic rf_wen, input logic csr_wen,
                                    input logic [4:0] rd, input logic [1:0] sel,
                                    input logic [2:0] f3, input logic [1:0] off,
                                    input logic [31:0] pc, input logic [31:0] alu);
    ins_t i;
    i.valid   = valid;
    i.rf_wen  = rf_wen;
    i.csr_wen = csr_wen;
    i.rd      = rd;
    i.sel     = sel;
    i.f3      = f3;
    i.off     = off;
    i.pc      = pc;
    i.alu     = alu;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.valid   = ($urandom % 4) != 0;
    i.pc      = ($urandom % 8 == 0) ? 32'hFFFF_FFFC : $urandom;
    i.alu     = $urandom;
    i.rd      = 5'($urandom);
    i.rf_wen  = 1'($urandom);
    i.csr_wen = ($urandom % 4) == 0;
    i.sel     = 2'($urandom);
    i.f3      = 3'($urandom);
    i.off     = 2'($urandom);
    return i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  ld_off [5] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [31:0] ld_exp [5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF,
                              32'h0000_7F01, 32'h80FF_7F01};

  initial begin
    // Reset held two cycles with random inputs.
    apply_stimulus(1'b1, 1'($urandom), rand_ins(), $urandom);
    tick();
    apply_stimulus(1'b1, 1'($urandom), rand_ins(), $urandom);
    tick();
    settle();
    check_output("reset.wen", 32'(bus.wen), 32'd0);
    check_output("reset.csr_load", 32'(bus.csr_load), 32'd0);
    check_output("reset.waddr", 32'(bus.waddr), 32'd0);
    check_output("reset.wdata", bus.wdata, 32'd0);
    check_output("reset.cycle", bus.cycle, 32'd0);
    check_output("reset.instret", bus.instret, 32'd0);

    // ALU write to x5, then the same instruction to x0.
    apply_stimulus(1'b0, 1'b0, make_ins(1, 1, 0, 5'd5, 2'd0, 3'd0, 2'd0, 32'h100, 32'h1234_5678), $urandom);
    tick();
    apply_stimulus(1'b0, 1'b0, make_ins(1, 1, 0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h104, 32'h1234_5678), $urandom);
    settle();
    check_output("alu.cycle", bus.cycle, 32'd1);
    check_output("alu.wen", 32'(bus.wen), 32'd1);
    check_output("alu.waddr", 32'(bus.waddr), 32'd5);
    check_output("alu.wdata", bus.wdata, 32'h1234_5678);
    check_output("alu.instret0", bus.instret, 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, BUBBLE, $urandom);
    settle();
    check_output("alu.instret1", bus.instret, 32'd1);
    check_output("x0.wen", 32'(bus.wen), 32'd0);
    tick();
    settle();
    check_output("x0.instret", bus.instret, 32'd2);
    check_output("bubble.wen", 32'(bus.wen), 32'd0);

    // Load alignment and extension.
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b0, 1'b0, make_ins(1, 1, 0, 5'd3, 2'd1, ld_f3[k], ld_off[k], 32'h200, $urandom), $urandom);
      tick();
      apply_stimulus(1'b0, 1'b0, BUBBLE, 32'h80FF_7F01);
      settle();
      check_output($sformatf("load%0d.wdata", k), bus.wdata, ld_exp[k]);
      check_output($sformatf("load%0d.wen", k), 32'(bus.wen), 32'd1);
    end

    // Stalled LB: the word from the first WB cycle must survive the stall.
    apply_stimulus(1'b0, 1'b0, make_ins(1, 1, 0, 5'd3, 2'd1, 3'b000, 2'd0, 32'h300, 32'd0), $urandom);
    tick();
    apply_stimulus(1'b0, 1'b1, BUBBLE, 32'h0000_00F0);
    settle();
    check_output("stall0.wen", 32'(bus.wen), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b1, BUBBLE, 32'hDEAD_BEEF);
    settle();
    check_output("stall1.wen", 32'(bus.wen), 32'd0);
    tick();
    settle();
    check_output("stall2.wen", 32'(bus.wen), 32'd0);
    tick();
    apply_stimulus(1'b0, 1'b0, BUBBLE, 32'hDEAD_BEEF);
    settle();
    check_output("release.wen", 32'(bus.wen), 32'd1);
    check_output("release.wdata", bus.wdata, 32'hFFFF_FFF0);
    check_output("release.instret", bus.instret, 32'd7);
    tick();
    settle();
    check_output("after.instret", bus.instret, 32'd8);
    check_output("after.wen", 32'(bus.wen), 32'd0);

    // CSR write and JAL link wrap.
    apply_stimulus(1'b0, 1'b0, make_ins(1, 0, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h400, 32'd7), $urandom);
    tick();
    apply_stimulus(1'b0, 1'b0, BUBBLE, $urandom);
    settle();
    check_output("csr.csr_load", 32'(bus.csr_load), 32'd1);
    check_output("csr.wdata", bus.wdata, 32'd7);
    apply_stimulus(1'b0, 1'b0, make_ins(1, 1, 0, 5'd1, 2'd2, 3'd0, 2'd0, 32'hFFFF_FFFC, 32'h55), $urandom);
    tick();
    apply_stimulus(1'b0, 1'b0, BUBBLE, $urandom);
    settle();
    check_output("jal.wdata", bus.wdata, 32'd0);
    check_output("jal.wen", 32'(bus.wen), 32'd1);

    // Randomized traffic, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      apply_stimulus(($urandom % 64) == 0, ($urandom % 4) == 0, rand_ins(), $urandom);
      tick();
    end

    // Reset while a stalled load sits in WB.
    apply_stimulus(1'b0, 1'b0, make_ins(1, 1, 0, 5'd9, 2'd1, 3'b010, 2'd0, 32'h500, 32'd0), $urandom);
    tick();
    apply_stimulus(1'b0, 1'b1, BUBBLE, 32'hA5A5_5A5A);
    tick();
    apply_stimulus(1'b0, 1'b1, BUBBLE, $urandom);
    tick();
    apply_stimulus(1'b1, 1'b1, BUBBLE, $urandom);
    tick();
    apply_stimulus(1'b0, 1'b0, BUBBLE, $urandom);
    settle();
    check_output("rststall.wen", 32'(bus.wen), 32'd0);
    check_output("rststall.held_valid", 32'(dut.held_valid), 32'd0);
    check_output("rststall.instret", bus.instret, 32'd0);
    check_output("rststall.cycle", bus.cycle, 32'd0);
    tick();
    settle();
    check_output("rststall.instret_after", bus.instret, 32'd0);
    check_output("rststall.cycle_after", bus.cycle, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
